// File: rtl/stack_cpu_driver_pkg.sv
// Shared constants for the stack calculator host driver: opcodes, pin map,
// FSM encoding and per-opcode execute-length helpers.
package stack_cpu_driver_pkg;

  localparam logic [3:0] OP_NOOP = 4'h0;
  localparam logic [3:0] OP_PUSH = 4'h1;
  localparam logic [3:0] OP_POP  = 4'h2;
  localparam logic [3:0] OP_OUTL = 4'h3;
  localparam logic [3:0] OP_OUTH = 4'h4;
  localparam logic [3:0] OP_ADD  = 4'h5;
  localparam logic [3:0] OP_SUB  = 4'h6;
  localparam logic [3:0] OP_SWAP = 4'h7;
  localparam logic [3:0] OP_BINA = 4'h8;
  localparam logic [3:0] OP_MULT = 4'h9;
  localparam logic [3:0] OP_DIV  = 4'hA;
  localparam logic [3:0] OP_CLFL = 4'hB;

  localparam logic [1:0] OUTMODE_LATCH = 2'b00;

  localparam int PIN_CLK      = 0;
  localparam int PIN_RST      = 1;
  localparam int PIN_NIB_LSB  = 2;
  localparam int PIN_MODE_LSB = 6;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RESET = 3'd1,
    ST_OPC   = 3'd2,
    ST_EXEC  = 3'd3,
    ST_WAIT  = 3'd4
  } drv_state_e;

  // Undefined opcodes run as NOOP on the calculator, hence a single edge.
  function automatic logic [1:0] exec_len(input logic [3:0] op);
    case (op)
      OP_BINA, OP_MULT, OP_DIV: exec_len = 2'd2;
      default:                  exec_len = 2'd1;
    endcase
  endfunction

  function automatic logic is_capture(input logic [3:0] op);
    is_capture = (op == OP_OUTL) || (op == OP_OUTH);
  endfunction

endpackage

// File: rtl/stack_cpu_driver_if.sv
// Host-side instruction/result signals plus the calculator pin bundle.
interface stack_cpu_driver_if;
  logic       start;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] instr_data;
  logic [7:0] cpu_io_in;
  logic [7:0] cpu_io_out;
  logic       result_valid;
  logic [7:0] result_data;
  logic       busy;

  modport master (
    output start, instr_valid, instr_data, cpu_io_out,
    input  instr_ready, cpu_io_in, result_valid, result_data, busy
  );

  modport slave (
    input  start, instr_valid, instr_data, cpu_io_out,
    output instr_ready, cpu_io_in, result_valid, result_data, busy
  );
endinterface

// File: rtl/stack_cpu_driver_fifo.sv
// Show-ahead synchronous instruction FIFO; a pop frees a full slot for a
// write in the same cycle.
module stack_cpu_driver_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             push_ok_s, pop_ok_s;

  assign empty_o = (cnt_q == {(AW+1){1'b0}});
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign rdata_o = mem_q[rd_ptr_q];

  always_comb begin
    pop_ok_s  = pop_i && !empty_o;
    push_ok_s = push_i && (!full_o || pop_ok_s);
    wr_ptr_d  = push_ok_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d  = pop_ok_s ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push_ok_s, pop_ok_s})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      cnt_q    <= {(AW+1){1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end
endmodule

// File: rtl/stack_cpu_driver.sv
// Host driver for the stack calculator: divided calculator clock, reset
// sequencing, nibble streaming from the FIFO and OUTL/OUTH result capture.
module stack_cpu_driver
  import stack_cpu_driver_pkg::*;
#(
  parameter int FIFO_DEPTH   = 8,
  parameter int HALF_PERIOD  = 2,
  parameter int RESET_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  stack_cpu_driver_if.slave  bus
);
  localparam int         DIV_W     = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [7:0] RST_EDGES = 8'(RESET_CYCLES);

  drv_state_e       state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             calc_clk_q, calc_clk_d;
  logic             rst_bit_q, rst_bit_d;
  logic [3:0]       nib_q, nib_d, op_q, op_d, arg_q, arg_d;
  logic [7:0]       edge_q, edge_d;
  logic             busy_q, busy_d, res_valid_q, res_valid_d;
  logic [7:0]       res_data_q, res_data_d;
  logic             run_s, tick_s, rise_s, fall_s, fetch_s, pop_s, push_s;
  logic             empty_s, full_s;
  logic [7:0]       rdata_s;

  assign push_s = bus.instr_valid && bus.instr_ready;

  stack_cpu_driver_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .wdata_i (bus.instr_data),
    .rdata_o (rdata_s),
    .empty_o (empty_s),
    .full_o  (full_s)
  );

  // Pins only move on a calc falling edge or while the calc clock is parked low.
  always_comb begin
    state_d     = state_q;
    calc_clk_d  = calc_clk_q;
    nib_d       = nib_q;
    rst_bit_d   = rst_bit_q;
    op_d        = op_q;
    arg_d       = arg_q;
    res_valid_d = 1'b0;
    res_data_d  = res_data_q;
    pop_s       = 1'b0;
    fetch_s     = 1'b0;
    run_s  = (state_q == ST_RESET) || (state_q == ST_OPC) || (state_q == ST_EXEC);
    tick_s = (div_q == DIV_W'(HALF_PERIOD - 1));
    rise_s = run_s && tick_s && !calc_clk_q;
    fall_s = run_s && tick_s && calc_clk_q;
    if (run_s) begin
      if (tick_s) begin
        div_d      = {DIV_W{1'b0}};
        calc_clk_d = !calc_clk_q;
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end else begin
      div_d      = {DIV_W{1'b0}};
      calc_clk_d = 1'b0;
    end
    if (rise_s) begin
      edge_d = edge_q + 8'd1;
    end else begin
      edge_d = edge_q;
    end

    case (state_q)
      ST_IDLE:  fetch_s = 1'b0;
      ST_RESET: fetch_s = fall_s && (edge_q == RST_EDGES);
      ST_OPC: begin
        if (fall_s) begin
          state_d = ST_EXEC;
          nib_d   = arg_q;
          edge_d  = 8'd0;
        end else begin
          state_d = ST_OPC;
        end
      end
      ST_EXEC: begin
        if (fall_s && (edge_q == {6'd0, exec_len(op_q)})) begin
          fetch_s = 1'b1;
          if (is_capture(op_q)) begin
            res_valid_d = 1'b1;
            res_data_d  = bus.cpu_io_out;
          end else begin
            res_valid_d = 1'b0;
          end
        end else begin
          fetch_s = 1'b0;
        end
      end
      ST_WAIT:  fetch_s = !empty_s;
      default:  state_d = ST_IDLE;
    endcase

    if (fetch_s) begin
      rst_bit_d = 1'b0;
      edge_d    = 8'd0;
      if (empty_s) begin
        state_d = ST_WAIT;
        nib_d   = 4'h0;
      end else begin
        pop_s   = 1'b1;
        state_d = ST_OPC;
        op_d    = rdata_s[3:0];
        arg_d   = rdata_s[7:4];
        nib_d   = rdata_s[3:0];
      end
    end else begin
      pop_s = 1'b0;
    end

    // A restart discards whatever was in flight but keeps queued entries.
    if (bus.start) begin
      state_d    = ST_RESET;
      rst_bit_d  = 1'b1;
      nib_d      = 4'h0;
      edge_d     = 8'd0;
      calc_clk_d = 1'b0;
      div_d      = {DIV_W{1'b0}};
      pop_s      = 1'b0;
    end else begin
      busy_d = 1'b0;
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      div_q       <= {DIV_W{1'b0}};
      calc_clk_q  <= 1'b0;
      rst_bit_q   <= 1'b0;
      nib_q       <= 4'h0;
      op_q        <= 4'h0;
      arg_q       <= 4'h0;
      edge_q      <= 8'd0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= 8'h00;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      calc_clk_q  <= calc_clk_d;
      rst_bit_q   <= rst_bit_d;
      nib_q       <= nib_d;
      op_q        <= op_d;
      arg_q       <= arg_d;
      edge_q      <= edge_d;
      busy_q      <= busy_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

  assign bus.cpu_io_in    = {OUTMODE_LATCH, nib_q, rst_bit_q, calc_clk_q};
  assign bus.instr_ready  = !full_s || pop_s;
  assign bus.result_valid = res_valid_q;
  assign bus.result_data  = res_data_q;
  assign bus.busy         = busy_q;
endmodule
